c6ib_ram_write_datapath: RTL and testbench
==========================================

// Module: c6ib_ram_write_datapath
// PURPOSE
//  Write datapath between the CNU6 IB-LUT generator and four IB RAM banks. Each group is
//  three 32-bit words (portA/B/C); the block serialises it into words 0,1,2 over three cycles.
//  Groups are steered round-robin to RAM0..RAM3, and one 5-bit page address is kept per RAM.
//  Write enable comes from the cnu6ib_control_unit (ram_write_en).
// PARAMETERS
//  DATA_W   32  word width of in_port*/port_out/interBank_data_ram*
//  PAGE_W    5  page address width per RAM (32 pages)
//  (RAM count = 4 and words/group = 3 are fixed constants, not parameters)
// PORTS
//  ram_clk              in   1       sole clock, rising edge
//  rstn                 in   1       asynchronous, active-low reset
//  en                   in   1       write enable (ram_write_en)
//  in_portA/B/C         in   DATA_W  word 0/1/2 of current group
//  port_out             out  DATA_W  serialised word presented this cycle
//  wr_valid             out  1       port_out/ram_sel hold a valid word
//  word_idx             out  2       index (0..2) of the word on port_out
//  ram_sel              out  2       target RAM of the word on port_out
//  interBank_data_ram0..3  out DATA_W  port_out if (wr_valid && ram_sel==N), else 0
//  page_addr_ram0..3    out  PAGE_W  current page of RAM N
// BEHAVIOUR
//  - rstn=0 (async): all internal/output regs 0 (port_out, wr_valid, word_idx, ram_sel,
//    issue phase, issue sel, shadow B/C, all page counters); interBank_data_ram* = 0.
//  - Issue state: phase_i (0..2), sel_i (0..3). On each rising edge with en=1:
//      phase_i==0: port_out<=in_portA; shadowB<=in_portB; shadowC<=in_portC
//      phase_i==1: port_out<=shadowB;  phase_i==2: port_out<=shadowC
//      ram_sel<=sel_i; word_idx<=phase_i; wr_valid<=1
//      phase_i <= (phase_i==2)?0:phase_i+1; sel_i <= sel_i+1 (mod 4) when phase_i==2
//  - Latency: word presented one cycle after the edge that issues it; B/C are taken from
//    the values sampled with A, so inputs may change freely after phase 0.
//  - en=0 on an edge: wr_valid<=0, port_out<=0, phase_i<=0 (partial group abandoned, no
//    page increment); sel_i, ram_sel, word_idx and page counters hold.
//  - interBank_data_ramN: combinational demux of registered port_out by ram_sel/wr_valid.
//  - Page counters: on an edge where wr_valid && word_idx==2 && ram_sel==N, page_N<=page_N+1.
//    page_addr_ramN = page_N (registered), so it is stable for all three words of a group.
//  - Wrap: sel_i 3->0; page_N 31->0 silently, no flag.
//  - Simultaneous en drop and group completion: the word_idx==2 increment still applies.
//  - Reset asserted mid-group clears everything immediately; the next group starts at
//    RAM0, page 0, word 0.
// STRUCTURE
//  - Shared package c6ib_pkg: DATA_W, PAGE_W, NUM_RAM=4, WORDS_PER_GRP=3, and the
//    ram_sel_t / page_addr_t typedefs.
//  - Sub-module c6ib_page_addr_gen: the four page counters, fed by wr_valid/word_idx/ram_sel.
//  - Top: issue FSM (phase_i/sel_i), shifter (shadow regs + mux), demux.
// TESTING
//  1 Reset: rstn=0 with en=1 toggling -> all outputs 0; release -> outputs stay 0 until
//    en=1.
//  2 Single group: A=1,B=2,C=3, en=1 for 3 cycles -> port_out 1,2,3, word_idx 0,1,2,
//    ram_sel 0; interBank_data_ram0 = 1,2,3 and ram1..3 = 0; page_addr_ram0 0 -> 1.
//  3 Round robin: 5 groups (1..3, 2..4, ...) -> ram_sel 0,1,2,3,0; after that
//    page_addr_ram0=2, ram1..3=1.
//  4 Wrap: 128 consecutive groups -> each page_addr_ramN reaches 31 then returns to 0;
//    ram_sel cycles 0..3 exactly 32 times.
//  5 en dropped after word 1 of a group on RAM2 -> wr_valid=0, port_out=0, page_addr_ram2
//    unchanged; next en restarts at word 0 (in_portA) still targeting RAM2.
//  6 Async rstn pulse mid-group (between clock edges) -> outputs clear immediately,
//    with no edge required.

Source files
------------

// File: rtl/c6ib_pkg.sv
// rtl/c6ib_pkg.sv - shared widths, counts and types for the IB RAM write datapath
package c6ib_pkg;

  localparam int DATA_W        = 32;
  localparam int PAGE_W        = 5;
  localparam int NUM_RAM       = 4;
  localparam int WORDS_PER_GRP = 3;

  typedef logic [1:0]        ram_sel_t;
  typedef logic [PAGE_W-1:0] page_addr_t;

  // Issue phase: which word of the current group goes out on the next edge
  typedef enum logic [1:0] {
    PH_W0 = 2'd0,
    PH_W1 = 2'd1,
    PH_W2 = 2'd2
  } phase_t;

endpackage

// File: rtl/c6ib_page_addr_gen.sv
// rtl/c6ib_page_addr_gen.sv - per-RAM page counters advanced on the last word of a group
module c6ib_page_addr_gen #(
  parameter int NUM_RAM = 4,
  parameter int PAGE_W  = 5
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             wr_valid,
  input  logic [1:0]                       word_idx,
  input  logic [1:0]                       ram_sel,
  output logic [NUM_RAM-1:0][PAGE_W-1:0]   page_addr
);

  logic [NUM_RAM-1:0][PAGE_W-1:0] page_q;

  // Bump the page of the RAM whose word 2 is on the bus; wraps silently at the top page
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      page_q <= '0;
    end else begin
      for (int n = 0; n < NUM_RAM; n++) begin
        if (wr_valid && (word_idx == 2'd2) && (ram_sel == 2'(n))) begin
          page_q[n] <= page_q[n] + PAGE_W'(1);
        end
      end
    end
  end

  assign page_addr = page_q;

endmodule

// File: rtl/c6ib_ram_write_datapath.sv
// rtl/c6ib_ram_write_datapath.sv - serialises 3-word groups round-robin onto four IB RAM banks
module c6ib_ram_write_datapath #(
  parameter int DATA_W = 32,
  parameter int PAGE_W = 5
) (
  input  logic              ram_clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [DATA_W-1:0] in_portA,
  input  logic [DATA_W-1:0] in_portB,
  input  logic [DATA_W-1:0] in_portC,
  output logic [DATA_W-1:0] port_out,
  output logic              wr_valid,
  output logic [1:0]        word_idx,
  output logic [1:0]        ram_sel,
  output logic [DATA_W-1:0] interBank_data_ram0,
  output logic [DATA_W-1:0] interBank_data_ram1,
  output logic [DATA_W-1:0] interBank_data_ram2,
  output logic [DATA_W-1:0] interBank_data_ram3,
  output logic [PAGE_W-1:0] page_addr_ram0,
  output logic [PAGE_W-1:0] page_addr_ram1,
  output logic [PAGE_W-1:0] page_addr_ram2,
  output logic [PAGE_W-1:0] page_addr_ram3
);

  import c6ib_pkg::*;

  phase_t            phase_q, phase_d;
  ram_sel_t          sel_q, sel_d;
  logic [DATA_W-1:0] shadow_b, shadow_c;
  logic [DATA_W-1:0] word_mux;
  logic [NUM_RAM-1:0][PAGE_W-1:0] page_addr;

  // Issue state register: current phase and target RAM of the group in flight
  always_ff @(posedge ram_clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= PH_W0;
      sel_q   <= '0;
    end else begin
      phase_q <= phase_d;
      sel_q   <= sel_d;
    end
  end

  // Next issue state: step through words 0..2, move to the next RAM after word 2; en low abandons the group
  always_comb begin
    phase_d = phase_q;
    sel_d   = sel_q;
    if (en) begin
      case (phase_q)
        PH_W0:   phase_d = PH_W1;
        PH_W1:   phase_d = PH_W2;
        PH_W2: begin
          phase_d = PH_W0;
          sel_d   = sel_q + 2'd1;
        end
        default: phase_d = PH_W0;
      endcase
    end else begin
      phase_d = PH_W0;
    end
  end

  // Word selection: A comes straight from the input, B/C from the copies taken alongside A
  always_comb begin
    word_mux = in_portA;
    case (phase_q)
      PH_W1:   word_mux = shadow_b;
      PH_W2:   word_mux = shadow_c;
      default: word_mux = in_portA;
    endcase
  end

  // Output register and shadows; en low clears the bus but keeps the last index/target visible
  always_ff @(posedge ram_clk or negedge rstn) begin
    if (!rstn) begin
      port_out <= '0;
      wr_valid <= 1'b0;
      word_idx <= 2'd0;
      ram_sel  <= 2'd0;
      shadow_b <= '0;
      shadow_c <= '0;
    end else if (en) begin
      if (phase_q == PH_W0) begin
        shadow_b <= in_portB;
        shadow_c <= in_portC;
      end
      port_out <= word_mux;
      wr_valid <= 1'b1;
      word_idx <= phase_q;
      ram_sel  <= sel_q;
    end else begin
      port_out <= '0;
      wr_valid <= 1'b0;
    end
  end

  c6ib_page_addr_gen #(
    .NUM_RAM (NUM_RAM),
    .PAGE_W  (PAGE_W)
  ) u_page_addr_gen (
    .clk       (ram_clk),
    .rstn      (rstn),
    .wr_valid  (wr_valid),
    .word_idx  (word_idx),
    .ram_sel   (ram_sel),
    .page_addr (page_addr)
  );

  assign page_addr_ram0 = page_addr[0];
  assign page_addr_ram1 = page_addr[1];
  assign page_addr_ram2 = page_addr[2];
  assign page_addr_ram3 = page_addr[3];

  assign interBank_data_ram0 = (wr_valid && ram_sel == 2'd0) ? port_out : '0;
  assign interBank_data_ram1 = (wr_valid && ram_sel == 2'd1) ? port_out : '0;
  assign interBank_data_ram2 = (wr_valid && ram_sel == 2'd2) ? port_out : '0;
  assign interBank_data_ram3 = (wr_valid && ram_sel == 2'd3) ? port_out : '0;

endmodule

// File: tb/tb_c6ib_ram_write_datapath.sv
// tb/tb_c6ib_ram_write_datapath.sv - table-driven and directed checks of the IB RAM write datapath
`timescale 1ns/1ps
module tb_c6ib_ram_write_datapath;

  logic        ram_clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [31:0] in_portA, in_portB, in_portC;
  logic [31:0] port_out;
  logic        wr_valid;
  logic [1:0]  word_idx;
  logic [1:0]  ram_sel;
  logic [31:0] ib0, ib1, ib2, ib3;
  logic [4:0]  pg0, pg1, pg2, pg3;

  int checks   = 0;
  int failures = 0;

  always #5 ram_clk = ~ram_clk;

  c6ib_ram_write_datapath dut (
    .ram_clk             (ram_clk),
    .rstn                (rstn),
    .en                  (en),
    .in_portA            (in_portA),
    .in_portB            (in_portB),
    .in_portC            (in_portC),
    .port_out            (port_out),
    .wr_valid            (wr_valid),
    .word_idx            (word_idx),
    .ram_sel             (ram_sel),
    .interBank_data_ram0 (ib0),
    .interBank_data_ram1 (ib1),
    .interBank_data_ram2 (ib2),
    .interBank_data_ram3 (ib3),
    .page_addr_ram0      (pg0),
    .page_addr_ram1      (pg1),
    .page_addr_ram2      (pg2),
    .page_addr_ram3      (pg3)
  );

  typedef struct {
    logic        en;
    logic [31:0] a, b, c;
    logic [31:0] out;
    logic        valid;
    logic [1:0]  idx;
    logic [1:0]  sel;
    logic [4:0]  p0, p1, p2, p3;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic e, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                              logic [31:0] o, logic v, logic [1:0] i, logic [1:0] s,
                              logic [4:0] p0, logic [4:0] p1, logic [4:0] p2, logic [4:0] p3);
    vec_t r;
    r.en = e; r.a = a; r.b = b; r.c = c;
    r.out = o; r.valid = v; r.idx = i; r.sel = s;
    r.p0 = p0; r.p1 = p1; r.p2 = p2; r.p3 = p3;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] o, input logic v,
                           input logic [1:0] i, input logic [1:0] s,
                           input logic [4:0] p0, input logic [4:0] p1,
                           input logic [4:0] p2, input logic [4:0] p3);
    chk({tag, ".port_out"}, port_out, o);
    chk({tag, ".wr_valid"}, 32'(wr_valid), 32'(v));
    chk({tag, ".word_idx"}, 32'(word_idx), 32'(i));
    chk({tag, ".ram_sel"},  32'(ram_sel),  32'(s));
    chk({tag, ".ib0"}, ib0, (v && s == 2'd0) ? o : 32'd0);
    chk({tag, ".ib1"}, ib1, (v && s == 2'd1) ? o : 32'd0);
    chk({tag, ".ib2"}, ib2, (v && s == 2'd2) ? o : 32'd0);
    chk({tag, ".ib3"}, ib3, (v && s == 2'd3) ? o : 32'd0);
    chk({tag, ".pg0"}, 32'(pg0), 32'(p0));
    chk({tag, ".pg1"}, 32'(pg1), 32'(p1));
    chk({tag, ".pg2"}, 32'(pg2), 32'(p2));
    chk({tag, ".pg3"}, 32'(pg3), 32'(p3));
  endtask

  task automatic step();
    @(posedge ram_clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    en = e; in_portA = a; in_portB = b; in_portC = c;
  endtask

  int sel_count[4];
  int g_exp_page;
  logic [4:0] tgt_page;

  initial begin
    rstn = 1'b0;
    drive(1'b1, 32'h5, 32'h6, 32'h7);

    // Reset held with en toggling: everything stays zero
    for (int k = 0; k < 4; k++) begin
      en = k[0];
      step();
    end
    check_all("rst_hold", 32'd0, 1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    en = 1'b0;
    rstn = 1'b1;
    step();
    step();
    check_all("rst_release", 32'd0, 1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    // Single group then round robin over five groups; 9s during words 1/2 must be ignored
    vecs[0]  = mk(1, 1, 2, 3,       1, 1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 9, 9, 9,       2, 1, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 9, 9, 9,       3, 1, 2, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 2, 3, 4,       2, 1, 0, 1, 1, 0, 0, 0);
    vecs[4]  = mk(1, 9, 9, 9,       3, 1, 1, 1, 1, 0, 0, 0);
    vecs[5]  = mk(1, 9, 9, 9,       4, 1, 2, 1, 1, 0, 0, 0);
    vecs[6]  = mk(1, 3, 4, 5,       3, 1, 0, 2, 1, 1, 0, 0);
    vecs[7]  = mk(1, 9, 9, 9,       4, 1, 1, 2, 1, 1, 0, 0);
    vecs[8]  = mk(1, 9, 9, 9,       5, 1, 2, 2, 1, 1, 0, 0);
    vecs[9]  = mk(1, 4, 5, 6,       4, 1, 0, 3, 1, 1, 1, 0);
    vecs[10] = mk(1, 9, 9, 9,       5, 1, 1, 3, 1, 1, 1, 0);
    vecs[11] = mk(1, 9, 9, 9,       6, 1, 2, 3, 1, 1, 1, 0);
    vecs[12] = mk(1, 5, 6, 7,       5, 1, 0, 0, 1, 1, 1, 1);
    vecs[13] = mk(1, 9, 9, 9,       6, 1, 1, 0, 1, 1, 1, 1);
    vecs[14] = mk(1, 9, 9, 9,       7, 1, 2, 0, 1, 1, 1, 1);
    vecs[15] = mk(0, 0, 0, 0,       0, 0, 2, 0, 2, 1, 1, 1);
    vecs[16] = mk(0, 0, 0, 0,       0, 0, 2, 0, 2, 1, 1, 1);

    for (int v = 0; v < 17; v++) begin
      drive(vecs[v].en, vecs[v].a, vecs[v].b, vecs[v].c);
      step();
      check_all($sformatf("vec%0d", v), vecs[v].out, vecs[v].valid, vecs[v].idx, vecs[v].sel,
                vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3);
    end

    // One group on RAM1 to bring the round robin to RAM2
    drive(1, 8, 9, 10); step();
    drive(1, 0, 0, 0);  step(); step();
    check_all("ram1_w2", 32'd10, 1'b1, 2'd2, 2'd1, 5'd2, 5'd1, 5'd1, 5'd1);

    // en dropped after word 1 on RAM2: group abandoned, page unchanged, restart at word 0 on RAM2
    drive(1, 32'h10, 32'h11, 32'h12); step();
    check_all("drop_w0", 32'h10, 1'b1, 2'd0, 2'd2, 5'd2, 5'd2, 5'd1, 5'd1);
    drive(1, 0, 0, 0); step();
    check_all("drop_w1", 32'h11, 1'b1, 2'd1, 2'd2, 5'd2, 5'd2, 5'd1, 5'd1);
    drive(0, 0, 0, 0); step();
    check_all("drop_off", 32'h0, 1'b0, 2'd1, 2'd2, 5'd2, 5'd2, 5'd1, 5'd1);
    step();
    check_all("drop_idle", 32'h0, 1'b0, 2'd1, 2'd2, 5'd2, 5'd2, 5'd1, 5'd1);
    drive(1, 32'h20, 32'h21, 32'h22); step();
    check_all("restart_w0", 32'h20, 1'b1, 2'd0, 2'd2, 5'd2, 5'd2, 5'd1, 5'd1);
    drive(1, 0, 0, 0); step(); step();
    check_all("restart_w2", 32'h22, 1'b1, 2'd2, 2'd2, 5'd2, 5'd2, 5'd1, 5'd1);
    drive(0, 0, 0, 0); step();
    check_all("restart_done", 32'h0, 1'b0, 2'd2, 2'd2, 5'd2, 5'd2, 5'd2, 5'd1);

    // Async reset pulse between edges while a group on RAM3 is in flight
    drive(1, 32'h30, 32'h31, 32'h32); step();
    check_all("pre_rst", 32'h30, 1'b1, 2'd0, 2'd3, 5'd2, 5'd2, 5'd2, 5'd1);
    #2 rstn = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 1'b0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    drive(1, 32'h40, 32'h41, 32'h42);
    #1 rstn = 1'b1;
    step();
    check_all("post_rst_w0", 32'h40, 1'b1, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    // Wrap: 128 back-to-back groups from a clean reset
    drive(0, 0, 0, 0);
    @(negedge ram_clk) rstn = 1'b0;
    @(negedge ram_clk) rstn = 1'b1;
    for (int n = 0; n < 4; n++) sel_count[n] = 0;
    for (int g = 0; g < 128; g++) begin
      drive(1, 32'(g * 3 + 100), 32'(g * 3 + 101), 32'(g * 3 + 102));
      step();
      if (wr_valid && word_idx == 2'd0 && ram_sel < 4) sel_count[ram_sel]++;
      chk($sformatf("wrap%0d.sel", g), 32'(ram_sel), 32'(g % 4));
      chk($sformatf("wrap%0d.a", g), port_out, 32'(g * 3 + 100));
      g_exp_page = (g / 4) % 32;
      case (g % 4)
        0:       tgt_page = pg0;
        1:       tgt_page = pg1;
        2:       tgt_page = pg2;
        default: tgt_page = pg3;
      endcase
      chk($sformatf("wrap%0d.page", g), 32'(tgt_page), 32'(g_exp_page));
      drive(1, 0, 0, 0);
      step();
      step();
      chk($sformatf("wrap%0d.c", g), port_out, 32'(g * 3 + 102));
    end
    drive(0, 0, 0, 0);
    step();
    for (int n = 0; n < 4; n++) chk($sformatf("wrap.count%0d", n), 32'(sel_count[n]), 32'd32);
    check_all("wrap_end", 32'h0, 1'b0, 2'd2, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
